circle_drawer: RTL and testbench
================================

Name: circle_drawer

Overview:
- Upstream pixel source for vga_adapter, a peer of fillscreen.
- Rasterises a circle outline with the integer midpoint (Bresenham) algorithm onto the 160x120 framebuffer.
- Emits one pixel per clock on the vga_x/vga_y/vga_colour/vga_plot bus and uses the same level-held start/done handshake as fillscreen.
- In the task top, it is selected onto the adapter after fillscreen has cleared the screen.

Parameters:
- SCREEN_W, 160, framebuffer width in pixels; x >= SCREEN_W is clipped.
- SCREEN_H, 120, framebuffer height in pixels; y >= SCREEN_H is clipped.

Ports:
- clk  input  1  system clock (CLOCK_50 domain)
- rst  input  1  asynchronous, active-high reset
- start  input  1  level request; held high until done is seen
- centre_x  input  8  circle centre x, unsigned
- centre_y  input  7  circle centre y, unsigned
- radius  input  8  radius in pixels, unsigned, 0..255
- colour  input  3  pixel colour
- done  output  1  high while in DONE
- vga_x  output  8  pixel x, valid when vga_plot=1
- vga_y  output  7  pixel y, valid when vga_plot=1
- vga_colour  output  3  colour latched at INIT
- vga_plot  output  1  write strobe to vga_adapter

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - done, vga_plot, vga_x, vga_y and vga_colour all read 0.
  - All internal registers clear.
  - Applies immediately, including mid-draw.
  - After rst falls, the block waits in IDLE for start.
- States: IDLE, INIT, OCT0..OCT7, DONE.
- IDLE -> INIT when start=1. Otherwise stay in IDLE with outputs 0.
- INIT, one cycle:
  - Latch centre_x, centre_y, radius and colour.
  - Set ox=radius, oy=0, crit=1-radius.
  - Go to OCT0.
  - Input changes after INIT are ignored until the next draw.
- OCTk, one cycle each, k=0..7. Candidate point (px,py) per octant:
  - OCT0: (cx+ox, cy+oy)
  - OCT1: (cx+oy, cy+ox)
  - OCT2: (cx-ox, cy+oy)
  - OCT3: (cx-oy, cy+ox)
  - OCT4: (cx-ox, cy-oy)
  - OCT5: (cx-oy, cy-ox)
  - OCT6: (cx+ox, cy-oy)
  - OCT7: (cx+oy, cy-ox)
- Coordinate arithmetic and clipping:
  - px and py are computed signed, at least 10 bits.
  - vga_plot=1 only if 0<=px<SCREEN_W and 0<=py<SCREEN_H; otherwise vga_plot=0.
  - Cycle timing is the same whether or not a point is clipped.
  - vga_x=px[7:0] and vga_y=py[6:0] in the same cycle as vga_plot. They are don't-care when vga_plot=0.
- Update, in the OCT7 cycle:
  - oy' = oy+1.
  - If crit<=0: crit' = crit + 2*oy' + 1, and ox is unchanged.
  - Else: ox' = ox-1 and crit' = crit + 2*(oy'-ox') + 1.
  - crit is signed, 11 bits.
- Next state after OCT7:
  - If oy' <= ox', go to OCT0.
  - Otherwise go to DONE.
- Latency:
  - A draw takes 8 plot cycles per iteration (N iterations).
  - done rises 2+8N clocks after start is first sampled high in IDLE.
  - radius=0 gives N=1: 8 plots at the centre.
- DONE:
  - done=1 and vga_plot=0.
  - Stay in DONE while start=1; go to IDLE the first cycle start=0.
- start falling mid-draw:
  - The draw completes.
  - DONE lasts exactly one cycle, then the block returns to IDLE.
- A new draw requires start to go low, then high again.
- Overlapping plots (same pixel written more than once) are permitted; no dedup.

Decomposition:
- vga_pkg holds:
  - SCREEN_W and SCREEN_H.
  - Coordinate width constants (X_W=8, Y_W=7).
  - colour_t (logic [2:0]).
  - The circle_state_t enum.
- Sub-module circle_octant_point: combinational.
  - Inputs: octant index, cx, cy, ox, oy.
  - Outputs: px, py, in_bounds.
  - Shared later by filled-circle and Reuleaux drawers.

Test Plan:
- Reset: rst=1 mid-draw (radius 40, cycle 100) -> outputs 0 on the same edge. After rst falls with start=1, the draw restarts from INIT and finishes 2+8N cycles later.
- r=0, centre (80,60), colour 3'b101 -> 8 plots, all at (80,60) with colour 5. done high at cycle 10 and held while start=1. IDLE one cycle after start drops.
- r=1, centre (80,60) -> N=2, 16 plot cycles, done at cycle 18.
  - First iteration, in order: (81,60),(80,61),(79,60),(80,61),(79,60),(80,59),(81,60),(80,59).
  - Second iteration: (81,61),(81,61),(79,61),(79,61),(79,59),(79,59),(81,59),(81,59).
- r=8, centre (80,60) -> N=6, done at cycle 50.
  - (ox,oy) sequence: (8,0),(8,1),(8,2),(7,3),(7,4),(6,5).
  - All 48 plots are in bounds.
- Clipping: centre (0,0), r=10 -> cycle count unchanged (done at 2+8N).
  - vga_plot=0 in every cycle with negative px/py.
  - (10,0) and (0,10) are plotted.
  - No vga_x/vga_y wrap-around is ever plotted.
- Handshake: start dropped during OCT3 of the first iteration, and centre/radius changed mid-draw -> the draw completes with the original latched values. done pulses for one cycle, then IDLE. No redraw until start rises again.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared framebuffer geometry, colour type and circle FSM encoding for the
// vga_adapter pixel sources.
package vga_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int C_W      = 10;  // signed candidate-coordinate width

  typedef logic [2:0] colour_t;

  // OCTk encodes k in the low three bits so the state doubles as octant index.
  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_INIT = 4'd1,
    S_DONE = 4'd2,
    S_OCT0 = 4'd8,
    S_OCT1 = 4'd9,
    S_OCT2 = 4'd10,
    S_OCT3 = 4'd11,
    S_OCT4 = 4'd12,
    S_OCT5 = 4'd13,
    S_OCT6 = 4'd14,
    S_OCT7 = 4'd15
  } circle_state_t;
endpackage

// File: rtl/circle_octant_point.sv
// Maps an octant index and the current (ox,oy) offset to a signed screen
// point and flags whether it lands inside the framebuffer.
module circle_octant_point import vga_pkg::*; #(
  parameter int SCREEN_W = vga_pkg::SCREEN_W,
  parameter int SCREEN_H = vga_pkg::SCREEN_H
) (
  input  logic [2:0]            oct,
  input  logic [X_W-1:0]        cx,
  input  logic [Y_W-1:0]        cy,
  input  logic signed [C_W-1:0] ox,
  input  logic signed [C_W-1:0] oy,
  output logic signed [C_W-1:0] px,
  output logic signed [C_W-1:0] py,
  output logic                  in_bounds
);
  localparam logic signed [C_W-1:0] W_LIM = C_W'(SCREEN_W);
  localparam logic signed [C_W-1:0] H_LIM = C_W'(SCREEN_H);

  logic signed [C_W-1:0] cxs, cys;
  assign cxs = $signed({2'b00, cx});
  assign cys = $signed({3'b000, cy});

  always_comb begin
    px = cxs + ox;
    py = cys + oy;
    case (oct)
      3'd0: begin px = cxs + ox; py = cys + oy; end
      3'd1: begin px = cxs + oy; py = cys + ox; end
      3'd2: begin px = cxs - ox; py = cys + oy; end
      3'd3: begin px = cxs - oy; py = cys + ox; end
      3'd4: begin px = cxs - ox; py = cys - oy; end
      3'd5: begin px = cxs - oy; py = cys - ox; end
      3'd6: begin px = cxs + ox; py = cys - oy; end
      default: begin px = cxs + oy; py = cys - ox; end
    endcase
  end

  assign in_bounds = (px >= 0) && (px < W_LIM) && (py >= 0) && (py < H_LIM);
endmodule

// File: rtl/circle_drawer.sv
// Midpoint circle outline rasteriser: one candidate pixel per clock across the
// eight octants, clipped to the framebuffer, with a level start/done handshake.
module circle_drawer import vga_pkg::*; #(
  parameter int SCREEN_W = vga_pkg::SCREEN_W,
  parameter int SCREEN_H = vga_pkg::SCREEN_H
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [X_W-1:0] centre_x,
  input  logic [Y_W-1:0] centre_y,
  input  logic [7:0]     radius,
  input  colour_t        colour,
  output logic           done,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output colour_t        vga_colour,
  output logic           vga_plot
);
  circle_state_t         state;
  logic [X_W-1:0]        cx_q;
  logic [Y_W-1:0]        cy_q;
  colour_t               col_q;
  logic signed [C_W-1:0] ox, oy, ox_n, oy_n;
  logic signed [10:0]    crit, crit_n;
  logic signed [C_W-1:0] px, py;
  logic                  in_bounds, is_oct;

  assign is_oct = state[3];

  circle_octant_point #(.SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)) u_pt (
    .oct(state[2:0]), .cx(cx_q), .cy(cy_q), .ox(ox), .oy(oy),
    .px(px), .py(py), .in_bounds(in_bounds)
  );

  // Decision-variable step applied once all eight octants of (ox,oy) are out.
  always_comb begin
    oy_n   = oy + 10'sd1;
    ox_n   = ox;
    crit_n = crit + {oy_n, 1'b0} + 11'sd1;
    if (crit > 11'sd0) begin
      ox_n   = ox - 10'sd1;
      crit_n = crit + {oy_n - ox_n, 1'b0} + 11'sd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cx_q  <= '0;
      cy_q  <= '0;
      col_q <= '0;
      ox    <= '0;
      oy    <= '0;
      crit  <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) state <= S_INIT;
        S_INIT: begin
          cx_q  <= centre_x;
          cy_q  <= centre_y;
          col_q <= colour;
          ox    <= $signed({2'b00, radius});
          oy    <= '0;
          crit  <= 11'sd1 - $signed({3'b000, radius});
          state <= S_OCT0;
        end
        S_OCT0, S_OCT1, S_OCT2, S_OCT3, S_OCT4, S_OCT5, S_OCT6:
          state <= circle_state_t'(state + 4'd1);
        S_OCT7: begin
          ox    <= ox_n;
          oy    <= oy_n;
          crit  <= crit_n;
          state <= (oy_n <= ox_n) ? S_OCT0 : S_DONE;
        end
        S_DONE: if (!start) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign done       = (state == S_DONE);
  assign vga_plot   = is_oct && in_bounds;
  assign vga_x      = is_oct ? px[X_W-1:0] : '0;
  assign vga_y      = is_oct ? py[Y_W-1:0] : '0;
  assign vga_colour = is_oct ? col_q : '0;
endmodule

// File: tb/tb_circle_drawer.sv
// Bench for circle_drawer: an integer midpoint model builds the expected plot
// list per draw and every cycle of the draw is compared against it.
module tb_circle_drawer;
  logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0] centre_x = '0, radius = '0;
  logic [6:0] centre_y = '0;
  logic [2:0] colour = '0;
  logic       done, vga_plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;

  int n_chk = 0, n_fail = 0;
  int mx[$], my[$], m_ox[$];

  circle_drawer dut (
    .clk(clk), .rst(rst), .start(start), .centre_x(centre_x), .centre_y(centre_y),
    .radius(radius), .colour(colour), .done(done), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected candidate points of a whole draw, in emission order.
  function automatic void build(int cx, int cy, int r);
    int ox, oy, crit;
    ox = r; oy = 0; crit = 1 - r;
    mx.delete(); my.delete(); m_ox.delete();
    do begin
      m_ox.push_back(ox);
      for (int o = 0; o < 8; o++) begin
        int u, v, sx, sy;
        u  = (o % 2 == 1) ? oy : ox;
        v  = (o % 2 == 1) ? ox : oy;
        sx = (o <= 1 || o >= 6) ? 1 : -1;
        sy = (o < 4) ? 1 : -1;
        mx.push_back(cx + sx * u);
        my.push_back(cy + sy * v);
      end
      oy++;
      if (crit <= 0) crit += 2 * oy + 1;
      else begin ox--; crit += 2 * (oy - ox) + 1; end
    end while (oy <= ox);
  endfunction

  // Called at a negedge. k counts clock edges since start was raised.
  task automatic draw(input int cx, input int cy, input int r, input int col,
                      input int drop_k, input int rst_k, input int hold,
                      output int s10, output int s01);
    int nexp, k_done, idx, inb, exp_done, last;
    s10 = 0; s01 = 0;
    build(cx, cy, r);
    nexp = mx.size(); k_done = 2 + nexp;
    last = (drop_k != 0) ? k_done : k_done + hold;
    centre_x = 8'(cx); centre_y = 7'(cy); radius = 8'(r); colour = 3'(col);
    start = 1'b1;
    for (int k = 1; k <= k_done + hold + 3; k++) begin
      @(posedge clk); #1;
      if (k == rst_k) begin
        rst = 1'b1; #1;
        chk("rst_done", int'(done), 0);
        chk("rst_plot", int'(vga_plot), 0);
        chk("rst_x", int'(vga_x), 0);
        chk("rst_y", int'(vga_y), 0);
        chk("rst_col", int'(vga_colour), 0);
        @(negedge clk); rst = 1'b0;
        return;
      end
      if (k >= 2 && k < k_done) begin
        idx = k - 2;
        inb = (mx[idx] >= 0 && mx[idx] < 160 && my[idx] >= 0 && my[idx] < 120) ? 1 : 0;
        chk("plot", int'(vga_plot), inb);
        if (inb == 1) begin
          chk("x", int'(vga_x), mx[idx]);
          chk("y", int'(vga_y), my[idx]);
          chk("colour", int'(vga_colour), col);
        end
      end else chk("plot_off", int'(vga_plot), 0);
      if (vga_plot) begin
        chk("no_wrap", (vga_x < 160 && vga_y < 120) ? 1 : 0, 1);
        if (vga_x == 10 && vga_y == 0) s10++;
        if (vga_x == 0 && vga_y == 10) s01++;
      end
      exp_done = (k >= k_done && k <= last) ? 1 : 0;
      chk("done", int'(done), exp_done);
      if (k == drop_k) begin
        start = 1'b0;
        centre_x = 8'($urandom); centre_y = 7'($urandom); radius = 8'($urandom);
        colour = ~colour;
      end
      if (drop_k == 0 && k == k_done + hold) start = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    int ex1x[16], ex1y[16], ex8[6];
    int s10, s01, rc;
    ex1x = '{81,80,79,80,79,80,81,80, 81,81,79,79,79,79,81,81};
    ex1y = '{60,61,60,61,60,59,60,59, 61,61,61,61,59,59,59,59};
    ex8  = '{8,8,8,7,7,6};

    // Pin the model against hand-derived sequences.
    build(80, 60, 0);
    chk("model_r0_n", mx.size(), 8);
    chk("model_r0_x", mx[5], 80);
    build(80, 60, 1);
    chk("model_r1_n", mx.size(), 16);
    for (int i = 0; i < 16; i++) begin
      chk("model_r1_x", mx[i], ex1x[i]);
      chk("model_r1_y", my[i], ex1y[i]);
    end
    build(80, 60, 8);
    chk("model_r8_n", mx.size(), 48);
    for (int i = 0; i < 6; i++) chk("model_r8_ox", m_ox[i], ex8[i]);

    repeat (3) @(negedge clk);
    chk("reset_done", int'(done), 0);
    chk("reset_plot", int'(vga_plot), 0);
    chk("reset_x", int'(vga_x), 0);
    chk("reset_col", int'(vga_colour), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_done", int'(done), 0);

    draw(80, 60, 0, 5, 0, 0, 3, s10, s01);
    draw(80, 60, 1, 2, 0, 0, 0, s10, s01);
    draw(80, 60, 8, 7, 0, 0, 1, s10, s01);
    draw(0, 0, 10, 4, 0, 0, 0, s10, s01);
    chk("clip_10_0", (s10 > 0) ? 1 : 0, 1);
    chk("clip_0_10", (s01 > 0) ? 1 : 0, 1);
    draw(80, 60, 20, 3, 5, 0, 6, s10, s01);
    draw(80, 60, 40, 6, 0, 100, 0, s10, s01);
    draw(80, 60, 40, 6, 0, 0, 0, s10, s01);

    for (int t = 0; t < 8; t++) begin
      rc = $urandom_range(0, 255);
      draw($urandom_range(0, 255), $urandom_range(0, 127), (t < 4) ? rc : rc % 40,
           $urandom_range(0, 7), (t % 3 == 2) ? $urandom_range(2, 9) : 0, 0,
           $urandom_range(0, 3), s10, s01);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
